// File: rtl/scanout_pkg.sv
// -----------------------------------------------------------------------------
// scanout_pkg
// Shared types for the frame buffer scanout path: pixel and SDRAM byte-address
// types, scanout FSM encoding and the frame buffer pixel stride.
// -----------------------------------------------------------------------------
package scanout_pkg;

    typedef logic [23:0] rgb_t;
    typedef logic [25:0] fb_addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } scan_state_e;

    // One 32-bit word per pixel in the frame buffer.
    localparam int BYTES_PER_PIXEL = 4;

endpackage

// File: rtl/scanout_fifo.sv
// -----------------------------------------------------------------------------
// scanout_fifo
// Synchronous first-word-fall-through FIFO: dout always shows the head entry,
// so a pop consumes the value visible in the same cycle.
// Ports:
//   clock, reset  - system clock, asynchronous active-high reset
//   push, din     - write strobe and data (ignored when full unless popping)
//   pop           - consume head entry (ignored when empty)
//   dout          - head entry, meaningful only while !empty
//   count         - number of stored entries
//   full, empty   - occupancy flags
// -----------------------------------------------------------------------------
module scanout_fifo
    import scanout_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = 24
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/framebuffer_scanout.sv
// -----------------------------------------------------------------------------
// framebuffer_scanout
// Reads one frame of 32-bit pixel words from SDRAM over a pipelined Avalon-MM
// read master and hands the RGB pixels to the VGA timing block as a
// valid/ready stream with start-of-frame and end-of-line markers.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for frame_start; base address latched on acceptance
// FETCH | issuing reads, throttled by FIFO space and in-flight limit
// DRAIN | all reads issued; waiting for the last pixel to leave
//
// Ports:
//   clock, reset             - system clock, asynchronous active-high reset
//   frame_buffer_base        - byte address of pixel (0,0)
//   frame_start              - one-cycle scan request (ignored unless IDLE)
//   busy, frame_done         - scan in progress / end-of-frame pulse
//   master_*                 - Avalon-MM pipelined read master
//   pixel_valid/ready/data   - RGB 8:8:8 pixel stream
//   pixel_sof, pixel_eol     - first pixel of frame / last pixel of line
// -----------------------------------------------------------------------------
module framebuffer_scanout
    import scanout_pkg::*;
#(
    parameter int H_RES           = 640,
    parameter int V_RES           = 480,
    parameter int FIFO_DEPTH      = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [25:0] frame_buffer_base,
    input  logic        frame_start,
    output logic        busy,
    output logic        frame_done,
    output logic [25:0] master_address,
    output logic        master_read,
    output logic [3:0]  master_byteenable,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    input  logic        master_waitrequest,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic [23:0] pixel_data,
    output logic        pixel_sof,
    output logic        pixel_eol
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_FETCH = FETCH;
    localparam logic [1:0] S_DRAIN = DRAIN;

    localparam int NPIX = H_RES * V_RES;
    localparam int RW   = $clog2(NPIX);
    localparam int OW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int XW   = $clog2(H_RES);
    localparam int YW   = $clog2(V_RES);

    logic [1:0]    state;
    fb_addr_t      base_q;
    logic [RW-1:0] req_idx;
    logic [OW-1:0] outstanding;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    rgb_t          fifo_dout;

    logic credit_ok;
    logic req_accept;
    logic pop;
    logic last_req;
    logic last_pix;
    logic unused_readdata_hi;

    assign unused_readdata_hi = ^master_readdata[31:24];

    // Pixel words returning plus words already buffered must fit in the FIFO,
    // so readdatavalid can never find it full. Neither term grows while a
    // request is stalled, so master_read stays up under waitrequest.
    assign credit_ok   = (int'(fifo_count) + int'(outstanding) < FIFO_DEPTH) &&
                         (int'(outstanding) < MAX_OUTSTANDING);
    assign master_read = (state == S_FETCH) && credit_ok;
    assign req_accept  = master_read & ~master_waitrequest;

    // Address is a pure function of registered state, so it holds while stalled.
    assign master_address    = base_q + fb_addr_t'(req_idx) * fb_addr_t'(BYTES_PER_PIXEL);
    assign master_byteenable = 4'hF;

    assign pixel_valid = ~fifo_empty;
    assign pixel_data  = pixel_valid ? fifo_dout : '0;
    assign pop         = pixel_valid & pixel_ready;
    assign pixel_sof   = pixel_valid && (x == '0) && (y == '0);
    assign pixel_eol   = pixel_valid && (x == XW'(H_RES - 1));
    assign busy        = (state != S_IDLE);

    assign last_req = (req_idx == RW'(NPIX - 1));
    assign last_pix = (x == XW'(H_RES - 1)) && (y == YW'(V_RES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            base_q     <= '0;
            req_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        state   <= S_FETCH;
                        base_q  <= frame_buffer_base;
                        req_idx <= '0;
                    end
                end
                S_FETCH: begin
                    if (req_accept) begin
                        if (last_req) state <= S_DRAIN;
                        else          req_idx <= req_idx + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (pop && last_pix) begin
                        state      <= S_IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
        end else if (state == S_IDLE && frame_start) begin
            outstanding <= '0;
        end else begin
            case ({req_accept, master_readdatavalid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (state == S_IDLE && frame_start) begin
            x <= '0;
            y <= '0;
        end else if (pop) begin
            if (x == XW'(H_RES - 1)) begin
                x <= '0;
                y <= (y == YW'(V_RES - 1)) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && master_readdatavalid) assert (!fifo_full);
    end

    scanout_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (24)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (master_readdatavalid),
        .pop   (pop),
        .din   (master_readdata[23:0]),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_framebuffer_scanout.sv
module tb_framebuffer_scanout;

    localparam int H_RES      = 4;
    localparam int V_RES      = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int MAX_OUT    = 3;
    localparam int NPIX       = H_RES * V_RES;

    logic        clock = 1'b0;
    logic        reset;
    logic [25:0] frame_buffer_base;
    logic        frame_start;
    logic        busy;
    logic        frame_done;
    logic [25:0] master_address;
    logic        master_read;
    logic [3:0]  master_byteenable;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        master_waitrequest;
    logic        pixel_valid;
    logic        pixel_ready;
    logic [23:0] pixel_data;
    logic        pixel_sof;
    logic        pixel_eol;

    framebuffer_scanout #(
        .H_RES           (H_RES),
        .V_RES           (V_RES),
        .FIFO_DEPTH      (FIFO_DEPTH),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .frame_buffer_base    (frame_buffer_base),
        .frame_start          (frame_start),
        .busy                 (busy),
        .frame_done           (frame_done),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_byteenable    (master_byteenable),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_waitrequest   (master_waitrequest),
        .pixel_valid          (pixel_valid),
        .pixel_ready          (pixel_ready),
        .pixel_data           (pixel_data),
        .pixel_sof            (pixel_sof),
        .pixel_eol            (pixel_eol)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          due;
        logic [25:0] addr;
    } rsp_t;

    rsp_t        rsp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 2;
    int          acc_cnt = 0;
    int          pix_cnt = 0;
    int          done_cnt = 0;
    int          inflight = 0;
    int          occ = 0;
    int          max_inflight = 0;
    int          stall_idx = -1;
    int          stall_left = 0;
    bit          stall_active = 1'b0;
    logic [25:0] base_m = '0;
    logic [25:0] stall_addr = '0;
    int          start_cyc = 0;
    int          first_rd_cyc = -1;
    int          first_pv_cyc = -1;
    int          last_pop_cyc = 0;
    int          done_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values();
        chk("rst_busy",       busy,              0);
        chk("rst_frame_done", frame_done,        0);
        chk("rst_read",       master_read,       0);
        chk("rst_address",    master_address,    0);
        chk("rst_byteenable", master_byteenable, 4'hF);
        chk("rst_valid",      pixel_valid,       0);
        chk("rst_data",       pixel_data,        0);
        chk("rst_sof",        pixel_sof,         0);
        chk("rst_eol",        pixel_eol,         0);
    endtask

    // One clock cycle, evaluated at the falling edge: drive the slave model,
    // check the cycle, then account for what the next rising edge will do.
    task automatic tick();
        logic        acc;
        logic        pop;
        logic [25:0] a;
        if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
            master_readdatavalid = 1'b1;
            master_readdata      = {8'hEE, 24'h800000 ^ rsp_q[0].addr[23:0]};
            void'(rsp_q.pop_front());
        end else begin
            master_readdatavalid = 1'b0;
            master_readdata      = 32'hDEAD_BEEF;
        end

        if (stall_left > 0 && (stall_active || (master_read && acc_cnt == stall_idx))) begin
            stall_active       = 1'b1;
            master_waitrequest = 1'b1;
            stall_left--;
            chk("stall_read", master_read, 1);
            chk("stall_addr", master_address, stall_addr);
        end else begin
            stall_active       = 1'b0;
            master_waitrequest = 1'b0;
        end

        chk("credit_bound", 32'(inflight + occ <= FIFO_DEPTH), 1);
        chk("outstanding_bound", 32'(inflight <= MAX_OUT), 1);
        chk("pixel_valid", pixel_valid, 32'(occ != 0));

        if (first_rd_cyc < 0 && master_read) first_rd_cyc = cyc;
        if (first_pv_cyc < 0 && pixel_valid) first_pv_cyc = cyc;
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end

        acc = master_read && !master_waitrequest;
        if (acc) begin
            a = base_m + 26'(4 * acc_cnt);
            chk("req_addr", master_address, a);
            rsp_q.push_back('{cyc + lat, master_address});
            acc_cnt++;
            inflight++;
        end

        pop = pixel_valid && pixel_ready;
        if (pop) begin
            a = base_m + 26'(4 * pix_cnt);
            chk("pixel_data", pixel_data, 24'h800000 ^ a[23:0]);
            chk("pixel_sof", pixel_sof, 32'(pix_cnt == 0));
            chk("pixel_eol", pixel_eol, 32'((pix_cnt % H_RES) == H_RES - 1));
            pix_cnt++;
            occ--;
            last_pop_cyc = cyc;
        end

        if (master_readdatavalid) begin
            inflight--;
            occ++;
        end
        if (inflight > max_inflight) max_inflight = inflight;
        cyc++;
        @(negedge clock);
    endtask

    task automatic start_frame(input logic [25:0] b);
        frame_buffer_base = b;
        base_m            = b;
        acc_cnt           = 0;
        pix_cnt           = 0;
        done_cnt          = 0;
        first_rd_cyc      = -1;
        first_pv_cyc      = -1;
        max_inflight      = 0;
        start_cyc         = cyc;
        frame_start       = 1'b1;
        tick();
        frame_start       = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(done_cnt != 0), 1);
    endtask

    task automatic end_checks();
        repeat (6) tick();
        chk("end_requests", acc_cnt, NPIX);
        chk("end_pixels", pix_cnt, NPIX);
        chk("end_done_once", done_cnt, 1);
        chk("end_done_timing", done_cyc - last_pop_cyc, 1);
        chk("end_busy", busy, 0);
        chk("end_fifo_empty", occ, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int n;
        reset                = 1'b1;
        frame_start          = 1'b0;
        frame_buffer_base    = '0;
        master_readdata      = '0;
        master_readdatavalid = 1'b0;
        master_waitrequest   = 1'b0;
        pixel_ready          = 1'b0;
        repeat (2) @(negedge clock);
        chk_reset_values();
        reset = 1'b0;
        tick();
        tick();

        // Basic frame: zero-wait slave, ready always high.
        pixel_ready = 1'b1;
        lat         = 2;
        start_frame(26'h100);
        chk("busy_after_start", busy, 1);
        wait_done(200, "t1_timeout");
        chk("t1_read_latency", first_rd_cyc - start_cyc, 1);
        chk("t1_valid_latency", first_pv_cyc - start_cyc, 4);
        end_checks();

        // Third request stalled by waitrequest for five cycles.
        stall_idx  = 2;
        stall_left = 5;
        stall_addr = 26'h108;
        start_frame(26'h100);
        wait_done(200, "t2_timeout");
        chk("t2_stall_used", stall_left, 0);
        end_checks();
        stall_idx = -1;

        // Downstream stalled: reads stop once FIFO credits are used up.
        pixel_ready = 1'b0;
        start_frame(26'h200);
        repeat (20) tick();
        chk("t3_stalled_requests", acc_cnt, 4);
        chk("t3_fifo_full", occ, 4);
        chk("t3_read_low", master_read, 0);
        chk("t3_busy", busy, 1);
        pixel_ready = 1'b1;
        wait_done(200, "t3_timeout");
        end_checks();

        // Slow slave: in-flight limit reached but never exceeded.
        lat = 10;
        start_frame(26'h400);
        wait_done(400, "t4_timeout");
        chk("t4_max_inflight", max_inflight, MAX_OUT);
        end_checks();

        // Second frame_start mid-frame must be ignored.
        lat = 2;
        start_frame(26'h100);
        repeat (3) tick();
        frame_buffer_base = 26'h3000;
        frame_start       = 1'b1;
        tick();
        frame_start       = 1'b0;
        wait_done(200, "t5_timeout");
        repeat (10) tick();
        end_checks();

        // Reset during FETCH with three reads in flight.
        lat = 10;
        start_frame(26'h40);
        n = 0;
        while (inflight < 3 && n < 20) begin
            tick();
            n++;
        end
        chk("t6_inflight_before_reset", inflight, 3);
        reset = 1'b1;
        #1;
        chk_reset_values();
        rsp_q.delete();
        inflight             = 0;
        occ                  = 0;
        master_readdatavalid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        lat   = 2;
        tick();
        // Base near the top of the address space: addresses wrap past zero.
        start_frame(26'h3FF_FFF8);
        wait_done(200, "t6_timeout");
        end_checks();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
